// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
module fifo_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       EN,
  input  logic                       CLR,
  input  logic                       WR,
  input  logic [WIDTH-1:0]           dataIn,
  input  logic                       RD,
  output logic [WIDTH-1:0]           dataOut,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       ALMOST_FULL,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT  = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             rd_acc;
  logic             wr_acc;

  assign EMPTY        = (count == '0);
  assign FULL         = (count == CNT_MAX);
  assign ALMOST_EMPTY = (count <= AE_CNT);
  assign ALMOST_FULL  = (count >= AF_CNT);

  // A write into a full FIFO is still accepted when a read frees a slot
  // in the same cycle.
  assign rd_acc = EN & RD & ~EMPTY;
  assign wr_acc = EN & WR & (~FULL | rd_acc);

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge Clk) begin
    if (Rst && wr_acc && !CLR) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      dataOut   <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (EN) begin
      if (CLR) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        if (rd_acc) begin
          dataOut <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + PTR_ONE;
        end
        if (wr_acc) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (wr_acc && !rd_acc) begin
          count <= count + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
          count <= count - CNT_ONE;
        end
        if (WR && !wr_acc) begin
          OVERFLOW <= 1'b1;
        end
        if (RD && EMPTY) begin
          UNDERFLOW <= 1'b1;
        end
      end
    end
  end

endmodule
